// File: rtl/screen_sequencer_pkg.sv
// Shared definitions for the screen-mode sequencer and the VGA overlay path.
// Holds the state encoding and the visible-row geometry.
package screen_sequencer_pkg;

    localparam int ROW_W        = 11;
    localparam int V_ACTIVE_DEF = 480;

    typedef logic [ROW_W-1:0] row_t;

    typedef enum logic [1:0] {
        ST_READY     = 2'd0,
        ST_PLAY      = 2'd1,
        ST_OVER_WIPE = 2'd2,
        ST_OVER_HOLD = 2'd3
    } state_e;

endpackage

// File: rtl/screen_sequencer_edge_detect.sv
// Two-flop edge detector: delays the input once and registers the selected
// edge strobe, so the strobe is high for one cycle, one cycle after the edge.
module edge_detect #(
    parameter logic RST_VAL = 1'b0,
    parameter bit   FALL    = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_edge
);

    logic r_q;
    logic r_edge;
    logic w_edge;

    assign w_edge = FALL ? (~i_sig & r_q) : (i_sig & ~r_q);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q    <= RST_VAL;
            r_edge <= 1'b0;
        end else begin
            r_q    <= i_sig;
            r_edge <= w_edge;
        end
    end

    assign o_edge = r_edge;

endmodule

// File: rtl/screen_sequencer.sv
// Screen-mode controller: READY -> PLAY -> OVER_WIPE -> OVER_HOLD -> READY,
// with a frame-synchronous top-down wipe row for the game-over overlay.
module screen_sequencer
    import screen_sequencer_pkg::*;
#(
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int WIPE_STEP   = 4,
    parameter int WIPE_DIV    = 1,
    parameter int HOLD_FRAMES = 120
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_vsync,
    input  logic             i_key_start,
    input  logic             i_game_over_evt,
    output logic             o_ready_sig,
    output logic             o_over_sig,
    output logic [ROW_W-1:0] o_wipe_row,
    output logic             o_game_rst_pulse,
    output logic             o_game_run,
    output logic [1:0]       o_state_dbg
);

    localparam int SUM_W  = ROW_W + 1;
    localparam int HOLD_W = (HOLD_FRAMES < 2) ? 1 : $clog2(HOLD_FRAMES + 1);

    localparam logic [7:0]        DIV_LAST = 8'(WIPE_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);
    localparam row_t              V_ROW    = ROW_W'(V_ACTIVE);

    logic w_key_rise;
    logic w_frame_tick;

    edge_detect #(.RST_VAL(1'b0), .FALL(1'b0)) u_key_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (i_key_start),
        .o_edge (w_key_rise)
    );

    edge_detect #(.RST_VAL(1'b1), .FALL(1'b1)) u_vsync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (i_vsync),
        .o_edge (w_frame_tick)
    );

    state_e            r_state;
    state_e            w_state_nxt;
    row_t              r_wipe_row;
    row_t              w_wipe_nxt;
    logic [7:0]        r_div;
    logic [7:0]        w_div_nxt;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_ready;
    logic              r_over;
    logic              r_run;
    logic              r_game_rst;

    // Sum is one bit wider than a row so the clamp sees overshoot past V_ACTIVE.
    logic [SUM_W-1:0] w_wipe_sum;
    row_t             w_wipe_step;

    assign w_wipe_sum  = {1'b0, r_wipe_row} + SUM_W'(WIPE_STEP);
    assign w_wipe_step = (w_wipe_sum >= SUM_W'(V_ACTIVE)) ? V_ROW : w_wipe_sum[ROW_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_READY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_wipe_nxt  = r_wipe_row;
        w_div_nxt   = r_div;
        w_hold_nxt  = r_hold_cnt;
        case (r_state)
            ST_READY: begin
                if (w_key_rise) begin
                    w_state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (i_game_over_evt) begin
                    w_state_nxt = ST_OVER_WIPE;
                    w_wipe_nxt  = '0;
                    w_div_nxt   = '0;
                end
            end
            ST_OVER_WIPE: begin
                if (w_frame_tick) begin
                    if (r_div == DIV_LAST) begin
                        w_div_nxt  = '0;
                        w_wipe_nxt = w_wipe_step;
                        if (w_wipe_step == V_ROW) begin
                            w_state_nxt = ST_OVER_HOLD;
                            w_hold_nxt  = '0;
                        end
                    end else begin
                        w_div_nxt = r_div + 8'd1;
                    end
                end
            end
            ST_OVER_HOLD: begin
                w_wipe_nxt = V_ROW;
                // An early key edge is dropped, not remembered for later.
                if (w_key_rise && (r_hold_cnt == HOLD_MAX)) begin
                    w_state_nxt = ST_READY;
                    w_wipe_nxt  = '0;
                end else if (w_frame_tick && (r_hold_cnt != HOLD_MAX)) begin
                    w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_READY;
            end
        endcase
    end

    // NOTE: the asynchronous reset clears every flop, so outputs reach their
    // idle values as soon as rst_n falls, without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wipe_row <= '0;
            r_div      <= '0;
            r_hold_cnt <= '0;
            r_ready    <= 1'b1;
            r_over     <= 1'b0;
            r_run      <= 1'b0;
            r_game_rst <= 1'b0;
        end else begin
            r_wipe_row <= w_wipe_nxt;
            r_div      <= w_div_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_ready    <= (w_state_nxt == ST_READY);
            r_over     <= (w_state_nxt == ST_OVER_WIPE) || (w_state_nxt == ST_OVER_HOLD);
            r_run      <= (w_state_nxt == ST_PLAY);
            r_game_rst <= (r_state == ST_READY) && (w_state_nxt == ST_PLAY);
        end
    end

    assign o_ready_sig      = r_ready;
    assign o_over_sig       = r_over;
    assign o_wipe_row       = r_wipe_row;
    assign o_game_rst_pulse = r_game_rst;
    assign o_game_run       = r_run;
    assign o_state_dbg      = r_state;

endmodule

// File: tb/tb_screen_sequencer.sv
// Directed bench for screen_sequencer: two instances (wipe step 4 and 7) share
// stimulus; output vector is {ready, over, run, rst_pulse, state[1:0], wipe[10:0]}.
module tb_screen_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vsync = 1'b1;
    logic key_start = 1'b0;
    logic game_over_evt = 1'b0;

    logic        a_ready, a_over, a_pulse, a_run;
    logic [10:0] a_wipe;
    logic [1:0]  a_state;
    logic        b_ready, b_over, b_pulse, b_run;
    logic [10:0] b_wipe;
    logic [1:0]  b_state;

    logic [16:0] obs_a;
    logic [16:0] obs_b;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    screen_sequencer #(.V_ACTIVE(480), .WIPE_STEP(4), .WIPE_DIV(1), .HOLD_FRAMES(120)) u_dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_vsync          (vsync),
        .i_key_start      (key_start),
        .i_game_over_evt  (game_over_evt),
        .o_ready_sig      (a_ready),
        .o_over_sig       (a_over),
        .o_wipe_row       (a_wipe),
        .o_game_rst_pulse (a_pulse),
        .o_game_run       (a_run),
        .o_state_dbg      (a_state)
    );

    screen_sequencer #(.V_ACTIVE(480), .WIPE_STEP(7), .WIPE_DIV(1), .HOLD_FRAMES(120)) u_dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_vsync          (vsync),
        .i_key_start      (key_start),
        .i_game_over_evt  (game_over_evt),
        .o_ready_sig      (b_ready),
        .o_over_sig       (b_over),
        .o_wipe_row       (b_wipe),
        .o_game_rst_pulse (b_pulse),
        .o_game_run       (b_run),
        .o_state_dbg      (b_state)
    );

    assign obs_a = {a_ready, a_over, a_run, a_pulse, a_state, a_wipe};
    assign obs_b = {b_ready, b_over, b_run, b_pulse, b_state, b_wipe};

    function automatic logic [16:0] pack(input logic rdy, input logic ov, input logic run,
                                         input logic pls, input logic [1:0] st, input int wipe);
        logic [10:0] w;
        w = wipe[10:0];
        return {rdy, ov, run, pls, st, w};
    endfunction

    function automatic int clamp_row(input int v);
        return (v > 480) ? 480 : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        vsync = 1'b0;
        step();
        step();
        vsync = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_reset();
        logic [16:0] e;
        e = pack(1, 0, 0, 0, 2'd0, 0);
        rst_n = 1'b0;
        repeat (3) step();
        if (obs_a !== e) begin $display("FAIL reset_hold_a: got %h exp %h", obs_a, e); n_err++; end
        n_vec++;
        if (obs_b !== e) begin $display("FAIL reset_hold_b: got %h exp %h", obs_b, e); n_err++; end
        n_vec++;
        rst_n = 1'b1;
        for (int f = 0; f < 3; f++) begin
            vsync = 1'b0;
            for (int c = 0; c < 10; c++) begin
                if (c == 2) vsync = 1'b1;
                step();
                if (obs_a !== e) begin $display("FAIL idle_a f%0d c%0d: got %h exp %h", f, c, obs_a, e); n_err++; end
                n_vec++;
                if (obs_b !== e) begin $display("FAIL idle_b f%0d c%0d: got %h exp %h", f, c, obs_b, e); n_err++; end
                n_vec++;
            end
        end
    endtask

    task automatic test_start();
        logic [16:0] e;
        key_start = 1'b1;
        step();
        e = pack(1, 0, 0, 0, 2'd0, 0);
        if (obs_a !== e) begin $display("FAIL start_lat_a: got %h exp %h", obs_a, e); n_err++; end
        n_vec++;
        step();
        e = pack(0, 0, 1, 1, 2'd1, 0);
        if (obs_a !== e) begin $display("FAIL start_pulse_a: got %h exp %h", obs_a, e); n_err++; end
        n_vec++;
        if (obs_b !== e) begin $display("FAIL start_pulse_b: got %h exp %h", obs_b, e); n_err++; end
        n_vec++;
        step();
        e = pack(0, 0, 1, 0, 2'd1, 0);
        if (obs_a !== e) begin $display("FAIL start_pulse_end_a: got %h exp %h", obs_a, e); n_err++; end
        n_vec++;
        if (obs_b !== e) begin $display("FAIL start_pulse_end_b: got %h exp %h", obs_b, e); n_err++; end
        n_vec++;
        // A fresh key edge during play changes nothing.
        key_start = 1'b0;
        step();
        step();
        key_start = 1'b1;
        step();
        step();
        step();
        if (obs_a !== e) begin $display("FAIL play_key_ignored_a: got %h exp %h", obs_a, e); n_err++; end
        n_vec++;
        key_start = 1'b0;
        step();
        step();
    endtask

    task automatic test_wipe();
        logic [16:0] e;
        int wa, wb, pa, pb;
        logic [1:0] sb, psb;
        game_over_evt = 1'b1;
        step();
        game_over_evt = 1'b0;
        e = pack(0, 1, 0, 0, 2'd2, 0);
        if (obs_a !== e) begin $display("FAIL over_entry_a: got %h exp %h", obs_a, e); n_err++; end
        n_vec++;
        if (obs_b !== e) begin $display("FAIL over_entry_b: got %h exp %h", obs_b, e); n_err++; end
        n_vec++;
        for (int k = 1; k <= 120; k++) begin
            pa  = clamp_row(4 * (k - 1));
            pb  = clamp_row(7 * (k - 1));
            psb = (pb == 480) ? 2'd3 : 2'd2;
            wa  = clamp_row(4 * k);
            wb  = clamp_row(7 * k);
            sb  = (wb == 480) ? 2'd3 : 2'd2;
            vsync = 1'b0;
            step();
            e = pack(0, 1, 0, 0, 2'd2, pa);
            if (obs_a !== e) begin $display("FAIL wipe_early_a k%0d: got %h exp %h", k, obs_a, e); n_err++; end
            n_vec++;
            e = pack(0, 1, 0, 0, psb, pb);
            if (obs_b !== e) begin $display("FAIL wipe_early_b k%0d: got %h exp %h", k, obs_b, e); n_err++; end
            n_vec++;
            step();
            e = pack(0, 1, 0, 0, (wa == 480) ? 2'd3 : 2'd2, wa);
            if (obs_a !== e) begin $display("FAIL wipe_a k%0d: got %h exp %h", k, obs_a, e); n_err++; end
            n_vec++;
            e = pack(0, 1, 0, 0, sb, wb);
            if (obs_b !== e) begin $display("FAIL wipe_b k%0d: got %h exp %h", k, obs_b, e); n_err++; end
            n_vec++;
            vsync = 1'b1;
            repeat (8) step();
            e = pack(0, 1, 0, 0, (wa == 480) ? 2'd3 : 2'd2, wa);
            if (obs_a !== e) begin $display("FAIL wipe_stable_a k%0d: got %h exp %h", k, obs_a, e); n_err++; end
            n_vec++;
        end
    endtask

    task automatic test_hold();
        logic [16:0] e_hold;
        logic [16:0] e;
        e_hold = pack(0, 1, 0, 0, 2'd3, 480);
        // Hold counts: A=0, B=51 at this point.
        repeat (50) frame();
        key_start = 1'b1;
        step();
        step();
        if (obs_a !== e_hold) begin $display("FAIL hold_early_key_a: got %h exp %h", obs_a, e_hold); n_err++; end
        n_vec++;
        if (obs_b !== e_hold) begin $display("FAIL hold_early_key_b: got %h exp %h", obs_b, e_hold); n_err++; end
        n_vec++;
        key_start = 1'b0;
        step();
        step();
        repeat (75) frame();
        if (obs_a !== e_hold) begin $display("FAIL hold_sat_a: got %h exp %h", obs_a, e_hold); n_err++; end
        n_vec++;
        key_start = 1'b1;
        step();
        if (obs_a !== e_hold) begin $display("FAIL hold_exit_lat_a: got %h exp %h", obs_a, e_hold); n_err++; end
        n_vec++;
        step();
        e = pack(1, 0, 0, 0, 2'd0, 0);
        if (obs_a !== e) begin $display("FAIL hold_exit_a: got %h exp %h", obs_a, e); n_err++; end
        n_vec++;
        if (obs_b !== e) begin $display("FAIL hold_exit_b: got %h exp %h", obs_b, e); n_err++; end
        n_vec++;
        key_start = 1'b0;
        step();
        step();
        // Second game: key held from hold frame 50 through frame 200.
        key_start = 1'b1;
        step();
        step();
        e = pack(0, 0, 1, 1, 2'd1, 0);
        if (obs_a !== e) begin $display("FAIL restart_a: got %h exp %h", obs_a, e); n_err++; end
        n_vec++;
        key_start = 1'b0;
        step();
        game_over_evt = 1'b1;
        step();
        game_over_evt = 1'b0;
        repeat (120) frame();
        if (obs_a !== e_hold) begin $display("FAIL rehold_a: got %h exp %h", obs_a, e_hold); n_err++; end
        n_vec++;
        if (obs_b !== e_hold) begin $display("FAIL rehold_b: got %h exp %h", obs_b, e_hold); n_err++; end
        n_vec++;
        repeat (50) frame();
        key_start = 1'b1;
        step();
        step();
        for (int f = 50; f < 200; f++) begin
            frame();
            if (obs_a !== e_hold) begin $display("FAIL held_key_a f%0d: got %h exp %h", f, obs_a, e_hold); n_err++; end
            n_vec++;
            if (obs_b !== e_hold) begin $display("FAIL held_key_b f%0d: got %h exp %h", f, obs_b, e_hold); n_err++; end
            n_vec++;
        end
        key_start = 1'b0;
        step();
        step();
        if (obs_a !== e_hold) begin $display("FAIL held_release_a: got %h exp %h", obs_a, e_hold); n_err++; end
        n_vec++;
    endtask

    task automatic test_reset_mid_wipe();
        logic [16:0] e;
        // Leave hold (both saturated), then start a new game.
        key_start = 1'b1;
        step();
        step();
        key_start = 1'b0;
        step();
        step();
        key_start = 1'b1;
        step();
        step();
        e = pack(0, 0, 1, 1, 2'd1, 0);
        if (obs_a !== e) begin $display("FAIL third_start_a: got %h exp %h", obs_a, e); n_err++; end
        n_vec++;
        key_start = 1'b0;
        step();
        step();
        // Key edge and game over reach the FSM on the same clock.
        key_start = 1'b1;
        step();
        game_over_evt = 1'b1;
        step();
        game_over_evt = 1'b0;
        key_start = 1'b0;
        e = pack(0, 1, 0, 0, 2'd2, 0);
        if (obs_a !== e) begin $display("FAIL key_and_over_a: got %h exp %h", obs_a, e); n_err++; end
        n_vec++;
        if (obs_b !== e) begin $display("FAIL key_and_over_b: got %h exp %h", obs_b, e); n_err++; end
        n_vec++;
        repeat (50) frame();
        e = pack(0, 1, 0, 0, 2'd2, 200);
        if (obs_a !== e) begin $display("FAIL mid_wipe_a: got %h exp %h", obs_a, e); n_err++; end
        n_vec++;
        e = pack(0, 1, 0, 0, 2'd2, 350);
        if (obs_b !== e) begin $display("FAIL mid_wipe_b: got %h exp %h", obs_b, e); n_err++; end
        n_vec++;
        #2;
        rst_n = 1'b0;
        #1;
        e = pack(1, 0, 0, 0, 2'd0, 0);
        if (obs_a !== e) begin $display("FAIL async_reset_a: got %h exp %h", obs_a, e); n_err++; end
        n_vec++;
        if (obs_b !== e) begin $display("FAIL async_reset_b: got %h exp %h", obs_b, e); n_err++; end
        n_vec++;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (obs_a !== e) begin $display("FAIL post_reset_a c%0d: got %h exp %h", c, obs_a, e); n_err++; end
            n_vec++;
        end
        key_start = 1'b1;
        step();
        step();
        e = pack(0, 0, 1, 1, 2'd1, 0);
        if (obs_a !== e) begin $display("FAIL post_reset_start_a: got %h exp %h", obs_a, e); n_err++; end
        n_vec++;
        key_start = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start();
        test_wipe();
        test_hold();
        test_reset_mid_wipe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
